logic_unit_pipe: RTL and testbench

- Parametrised, pipelined logic functional unit for the Tomasulo datapath. It is the next generation of the fixed 32-bit bitwise AND gate.
- Accepts an issued op from its reservation station via valid/ready, with two operands, an opcode and an ROB/RS tag.
- Computes one of eight bitwise functions and carries the tag through STAGES register stages.
- Presents the result to the CDB arbiter. Results are held until the arbiter grants the bus.
- Supports flush on mispredict.

---
 rtl/logic_unit_pipe_pkg.sv | 19 +
 rtl/logic_unit_pipe_op_core.sv | 31 +++
 rtl/logic_unit_pipe.sv | 107 ++++++++++
 tb/tb_logic_unit_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined logic functional unit: opcode
// encoding and default datapath widths.
package logic_unit_defs;

    localparam int unsigned LU_WIDTH = 32;
    localparam int unsigned LU_TAG_W = 4;

    typedef enum logic [2:0] {
        LOP_AND   = 3'b000,
        LOP_OR    = 3'b001,
        LOP_XOR   = 3'b010,
        LOP_NOR   = 3'b011,
        LOP_NAND  = 3'b100,
        LOP_XNOR  = 3'b101,
        LOP_ANDN  = 3'b110,
        LOP_PASSA = 3'b111
    } lop_e;

endpackage

// File: rtl/logic_unit_pipe_op_core.sv
// Combinational bitwise function core: y = f(op, a, b) across WIDTH bits,
// plus a result-is-zero flag.
module logic_op_core
    import logic_unit_defs::*;
#(
    parameter int unsigned WIDTH = LU_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o
);

    always_comb begin
        y_o = '0;
        case (lop_e'(op_i))
            LOP_AND:   y_o = a_i & b_i;
            LOP_OR:    y_o = a_i | b_i;
            LOP_XOR:   y_o = a_i ^ b_i;
            LOP_NOR:   y_o = ~(a_i | b_i);
            LOP_NAND:  y_o = ~(a_i & b_i);
            LOP_XNOR:  y_o = ~(a_i ^ b_i);
            LOP_ANDN:  y_o = a_i & ~b_i;
            LOP_PASSA: y_o = a_i;
            default:   y_o = a_i;
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic functional unit: valid/ready issue, STAGES register
// stages carrying {valid, data, tag, zero}, result held until CDB grant.
module logic_unit_pipe
    import logic_unit_defs::*;
#(
    parameter int unsigned WIDTH  = LU_WIDTH,
    parameter int unsigned TAG_W  = LU_TAG_W,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [WIDTH-1:0] cdb_data,
    output logic [TAG_W-1:0] cdb_tag,
    output logic             cdb_zero,
    output logic             busy
);

    logic [WIDTH-1:0] core_y;
    logic             core_zero;

    logic [STAGES-1:0] v_q, vld_d, adv, load;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op_i   (in_op),
        .a_i    (in_a),
        .b_i    (in_b),
        .y_o    (core_y),
        .zero_o (core_zero)
    );

    // Advance ripples back from the CDB grant so a full pipe can shift
    // and accept in the same cycle without a bubble.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = v_q[STAGES-1] & cdb_grant;
        for (int unsigned k = 1; k < STAGES; k++) begin
            adv[STAGES-1-k] = !v_q[STAGES-k] | adv[STAGES-k];
        end
        load = ~v_q | adv;
    end

    always_comb begin
        vld_d  = v_q;
        zero_d = zero_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (load[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = core_y;
                tag_d[0]  = in_tag;
                zero_d[0] = core_zero;
            end
        end
        for (int unsigned s = 1; s < STAGES; s++) begin
            if (load[s]) begin
                vld_d[s] = v_q[s-1];
                if (v_q[s-1]) begin
                    data_d[s] = data_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                    zero_d[s] = zero_q[s-1];
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            zero_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            v_q    <= vld_d;
            zero_q <= zero_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign in_ready = load[0];
    assign busy     = |v_q;
    assign cdb_req  = v_q[STAGES-1];
    assign cdb_data = data_q[STAGES-1];
    assign cdb_tag  = tag_q[STAGES-1];
    assign cdb_zero = zero_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised bench for logic_unit_pipe: three configurations driven in
// lockstep and checked against a queue-based occupancy model.
module tb_logic_unit_pipe;

    localparam int DEPTH [3] = '{2, 1, 4};
    localparam int WID   [3] = '{32, 8, 64};

    logic        clk, rst_n, in_valid, flush, cdb_grant;
    logic [2:0]  in_op;
    logic [63:0] in_a, in_b;
    logic [3:0]  in_tag;

    logic        rdy_s2, req_s2, zero_s2, busy_s2;
    logic [31:0] data_s2;
    logic [3:0]  tag_s2;
    logic        rdy_s1, req_s1, zero_s1, busy_s1;
    logic [7:0]  data_s1;
    logic [3:0]  tag_s1;
    logic        rdy_s4, req_s4, zero_s4, busy_s4;
    logic [63:0] data_s4;
    logic [3:0]  tag_s4;

    logic        rdy_o  [3];
    logic        req_o  [3];
    logic        zero_o [3];
    logic        busy_o [3];
    logic [63:0] data_o [3];
    logic [3:0]  tag_o  [3];

    logic_unit_pipe #(.WIDTH(32), .TAG_W(4), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s2),
        .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
        .flush(flush), .cdb_req(req_s2), .cdb_grant(cdb_grant),
        .cdb_data(data_s2), .cdb_tag(tag_s2), .cdb_zero(zero_s2), .busy(busy_s2)
    );

    logic_unit_pipe #(.WIDTH(8), .TAG_W(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s1),
        .in_op(in_op), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_tag(in_tag),
        .flush(flush), .cdb_req(req_s1), .cdb_grant(cdb_grant),
        .cdb_data(data_s1), .cdb_tag(tag_s1), .cdb_zero(zero_s1), .busy(busy_s1)
    );

    logic_unit_pipe #(.WIDTH(64), .TAG_W(4), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .flush(flush), .cdb_req(req_s4), .cdb_grant(cdb_grant),
        .cdb_data(data_s4), .cdb_tag(tag_s4), .cdb_zero(zero_s4), .busy(busy_s4)
    );

    assign rdy_o[0] = rdy_s2;  assign rdy_o[1] = rdy_s1;  assign rdy_o[2] = rdy_s4;
    assign req_o[0] = req_s2;  assign req_o[1] = req_s1;  assign req_o[2] = req_s4;
    assign zero_o[0] = zero_s2; assign zero_o[1] = zero_s1; assign zero_o[2] = zero_s4;
    assign busy_o[0] = busy_s2; assign busy_o[1] = busy_s1; assign busy_o[2] = busy_s4;
    assign data_o[0] = {32'b0, data_s2};
    assign data_o[1] = {56'b0, data_s1};
    assign data_o[2] = data_s4;
    assign tag_o[0] = tag_s2;  assign tag_o[1] = tag_s1;  assign tag_o[2] = tag_s4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pos;
        logic [63:0] data;
        logic [3:0]  tag;
    } item_t;

    item_t       mq [3][$];
    logic [63:0] gold [$];
    bit          gold_en;
    bit          mv [3][4];
    bit          exp_rdy [3];
    int          vectors;
    int          miscompares;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r, m;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: r = ~(a & b);
            3'd5: r = ~(a ^ b);
            3'd6: r = a & ~b;
            default: r = a;
        endcase
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return r & m;
    endfunction

    task automatic check_outputs();
        for (int d = 0; d < 3; d++) begin
            bit er;
            er = (mq[d].size() > 0) && (mq[d][0].pos == DEPTH[d] - 1);
            check_val($sformatf("cdb_req[%0d]", d), 64'(req_o[d]), 64'(er));
            check_val($sformatf("busy[%0d]", d), 64'(busy_o[d]), 64'(mq[d].size() != 0));
            if (er) begin
                check_val($sformatf("cdb_data[%0d]", d), data_o[d], mq[d][0].data);
                check_val($sformatf("cdb_tag[%0d]", d), 64'(tag_o[d]), 64'(mq[d][0].tag));
                check_val($sformatf("cdb_zero[%0d]", d), 64'(zero_o[d]), 64'(mq[d][0].data == 64'd0));
            end
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] tg, input logic fl,
                        input logic gr);
        @(negedge clk);
        check_outputs();
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tg;
        flush = fl; cdb_grant = gr;
        #1;
        for (int d = 0; d < 3; d++) begin
            int n;
            n = mq[d].size();
            for (int k = 0; k < n; k++) begin
                if (k == 0)
                    mv[d][k] = (mq[d][0].pos == DEPTH[d] - 1) ? gr : 1'b1;
                else
                    mv[d][k] = (mq[d][k-1].pos == mq[d][k].pos + 1) ? mv[d][k-1] : 1'b1;
            end
            exp_rdy[d] = (n == 0) || (mq[d][n-1].pos != 0) || mv[d][n-1];
            check_val($sformatf("in_ready[%0d]", d), 64'(rdy_o[d]), 64'(exp_rdy[d]));
        end
        for (int d = 0; d < 3; d++) begin
            bit pop, acc;
            int n;
            n   = mq[d].size();
            acc = v && exp_rdy[d];
            if (fl) begin
                mq[d].delete();
            end else begin
                pop = (n > 0) && (mq[d][0].pos == DEPTH[d] - 1) && gr;
                if (d == 0 && gold_en && pop && gold.size() > 0)
                    check_val("basic_gold", data_o[0], gold.pop_front());
                for (int k = 0; k < n; k++) begin
                    item_t it;
                    it = mq[d][k];
                    if (mv[d][k]) it.pos++;
                    mq[d][k] = it;
                end
                if (pop) void'(mq[d].pop_front());
                if (acc) mq[d].push_back('{0, ref_op(op, a, b, WID[d]), tg});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("%s_req[%0d]", tag, d), 64'(req_o[d]), 64'd0);
            check_val($sformatf("%s_busy[%0d]", tag, d), 64'(busy_o[d]), 64'd0);
            check_val($sformatf("%s_data[%0d]", tag, d), data_o[d], 64'd0);
            check_val($sformatf("%s_tag[%0d]", tag, d), 64'(tag_o[d]), 64'd0);
            check_val($sformatf("%s_zero[%0d]", tag, d), 64'(zero_o[d]), 64'd0);
            check_val($sformatf("%s_ready[%0d]", tag, d), 64'(rdy_o[d]), 64'd1);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
        #1 check_reset_state("mid_rst");
        for (int d = 0; d < 3; d++) mq[d].delete();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; gold_en = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; cdb_grant = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Basic ops, back-to-back with grant held high
        gold = '{64'h00F0_1234, 64'hFFF0_FFFF, 64'hFF00_EDCB, 64'h000F_0000,
                 64'hFF0F_EDCB, 64'h00FF_1234, 64'hF000_0000, 64'hF0F0_1234};
        gold_en = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'b1, 3'(i), 64'hF0F0_1234, 64'h0FF0_FFFF, 4'(i), 1'b0, 1'b1);
        idle(5);
        gold_en = 1'b0;
        check_val("gold_drain", 64'(gold.size()), 64'd0);

        // Zero flag
        step(1'b1, 3'd0, 64'hAAAA_AAAA, 64'h5555_5555, 4'd7, 1'b0, 1'b1);
        idle(5);

        // Backpressure, then grant with tag 3 re-offered
        for (int t = 1; t <= 3; t++)
            step(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                 4'(t), 1'b0, 1'b0);
        step(1'b1, 3'd1, {$urandom, $urandom}, {$urandom, $urandom}, 4'd3, 1'b0, 1'b1);
        idle(6);

        // Flush with a simultaneous offer
        for (int t = 0; t < 2; t++)
            step(1'b1, 3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 4'(t + 8), 1'b0, 1'b0);
        step(1'b1, 3'd5, {$urandom, $urandom}, {$urandom, $urandom}, 4'd10, 1'b1, 1'b1);
        idle(6);

        // Async reset while stalled full
        for (int t = 0; t < 5; t++)
            step(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                 4'(t + 11), 1'b0, 1'b0);
        async_reset();
        step(1'b1, 3'd4, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 4'd6, 1'b0, 1'b1);
        idle(6);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));
        idle(6);
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
